// File: rtl/hazard_scoreboard.sv
// Destination-tag tracker for the ID->EX->MEM->WB pipe with a single-bubble load-use interlock.
// Define HAZ_STALL_CNT_EN to add stallCnt, a saturating count of stalled cycles.
module hazard_scoreboard #(
    parameter int               REG_W   = 4,
    parameter logic [REG_W-1:0] NOP_TAG = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_ID,
    input  logic [REG_W-1:0]        rdReg1_ID,
    input  logic [REG_W-1:0]        rdReg2_ID,
    input  logic                    rdUse1_ID,
    input  logic                    rdUse2_ID,
    input  logic [REG_W-1:0]        wrReg_ID,
    input  logic                    regWrite_ID,
    input  logic                    memRead_ID,
    input  logic                    flush,
    output logic                    stall_ID,
    output logic [REG_W-1:0]        wrReg_EX,
    output logic [REG_W-1:0]        wrReg_MEM,
    output logic [REG_W-1:0]        wrReg_WB,
    output logic                    ldPend_EX,
    output logic [(2**REG_W)-1:0]   busyMask
`ifdef HAZ_STALL_CNT_EN
    ,
    output logic [15:0]             stallCnt
`endif
);

    logic             liveId;
    logic [REG_W-1:0] tagId;
    logic             hit1;
    logic             hit2;

    // Register 0 is never tracked, so a write to it issues as a bubble tag.
    assign liveId = valid_ID && regWrite_ID && (wrReg_ID != '0);
    assign tagId  = liveId ? wrReg_ID : NOP_TAG;

    // Contract: ID advances on a cycle where valid_ID=1 and stall_ID=0; while
    // stall_ID=1 the ID instruction is held and a bubble enters EX instead.
    assign hit1     = rdUse1_ID && (rdReg1_ID == wrReg_EX);
    assign hit2     = rdUse2_ID && (rdReg2_ID == wrReg_EX);
    assign stall_ID = valid_ID && ldPend_EX && !flush && (hit1 || hit2);

    always_ff @(posedge clk) begin
        if (rst) begin
            wrReg_EX  <= NOP_TAG;
            wrReg_MEM <= NOP_TAG;
            wrReg_WB  <= NOP_TAG;
            ldPend_EX <= 1'b0;
        end else begin
            wrReg_WB  <= wrReg_MEM;
            wrReg_MEM <= wrReg_EX;
            if (flush || stall_ID) begin
                wrReg_EX  <= NOP_TAG;
                ldPend_EX <= 1'b0;
            end else begin
                wrReg_EX  <= tagId;
                ldPend_EX <= memRead_ID && liveId;
            end
        end
    end

    always_comb begin
        busyMask = '0;
        if (wrReg_EX != NOP_TAG)  busyMask[wrReg_EX]  = 1'b1;
        if (wrReg_MEM != NOP_TAG) busyMask[wrReg_MEM] = 1'b1;
        if (wrReg_WB != NOP_TAG)  busyMask[wrReg_WB]  = 1'b1;
        busyMask[0] = 1'b0;
    end

`ifdef HAZ_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stallCnt <= '0;
        end else if (stall_ID && (stallCnt != 16'hFFFF)) begin
            stallCnt <= stallCnt + 16'd1;
        end
    end
`endif

endmodule
